branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Parameters
REQ-001 The block SHALL have parameter BHT_ENTRIES, default 16, meaning the number of 2-bit prediction counters; it SHALL be a power of 2 and at least 2.
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning the counter index width; it SHALL equal log2(BHT_ENTRIES).
REQ-003 The block SHALL have parameter ADDR_W, default 10, meaning the width of a return address.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 8, meaning the number of return-stack entries; it SHALL be a power of 2.

Interface
REQ-005 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 PRED_VALID  in  1  predict lookup request.
REQ-008 PRED_IDX  in  IDX_W  counter index for the lookup.
REQ-009 PRED_TAKEN  out  1  registered prediction.
REQ-010 RES_VALID  in  1  resolve request.
REQ-011 RES_TYPE  in  4  branch code: 0 none, 1 BRCC, 2 BRCS, 3 BREQ, 4 BRN, 5 BRNE, 6 CALL, 7 RET, 8 RETID, 9 RETIE, A-F reserved.
REQ-012 C, Z  in  1 each  flags for resolution.
REQ-013 RES_IDX  in  IDX_W  counter index of the branch being resolved.
REQ-014 RES_PREDICTED  in  1  prediction that was used for this branch.
REQ-015 RES_RET_ADDR  in  ADDR_W  return address pushed on CALL.
REQ-016 BRANCH_TAKEN  out  1  registered resolved outcome.
REQ-017 BRANCH_MISS  out  1  registered; equals BRANCH_TAKEN xor RES_PREDICTED.
REQ-018 RES_DONE  out  1  one-cycle pulse marking valid BRANCH_TAKEN/BRANCH_MISS.
REQ-019 RAS_TOP  out  ADDR_W  address popped by the last RET/RETID/RETIE.
REQ-020 RAS_EMPTY  out  1  high when the stack holds zero entries.
REQ-021 RAS_UNDERFLOW  out  1  one-cycle pulse on a pop from an empty stack.

Function
REQ-022 Prediction latency SHALL be 1 cycle: PRED_TAKEN takes the MSB of counter[PRED_IDX] when PRED_VALID is high, and holds its value otherwise.
REQ-023 Resolution latency SHALL be 1 cycle: when RES_VALID is high, the next edge SHALL register BRANCH_TAKEN per the taken rules (REQ-024, REQ-025), register BRANCH_MISS, and pulse RES_DONE.
REQ-024 Conditional taken rules: BRCC taken if C=0; BRCS taken if C=1; BREQ taken if Z=1; BRNE taken if Z=0.
REQ-025 Unconditional taken rules: types 4, 6, 7, 8 and 9 are always taken; types 0 and A-F are never taken.
REQ-026 When RES_VALID is low, RES_DONE SHALL be 0, and BRANCH_TAKEN/BRANCH_MISS SHALL hold their values.
REQ-027 Counter update: only types 1, 2, 3 and 5 SHALL update counter[RES_IDX]; taken increments and not-taken decrements, saturating at 0 and 3.
REQ-028 Types 4 and 6-F SHALL NOT modify any counter.
REQ-029 If the same index is predicted and updated in one cycle, the prediction SHALL use the pre-update value (no bypass).
REQ-030 Return stack is a circular buffer with write pointer WP and count CNT (0..RAS_DEPTH).
REQ-031 CALL SHALL write RES_RET_ADDR at WP, increment WP modulo RAS_DEPTH, and increment CNT, saturating at RAS_DEPTH.
REQ-032 A CALL while full SHALL overwrite the oldest entry; CNT stays at RAS_DEPTH.
REQ-033 RET/RETID/RETIE with CNT>0 SHALL decrement WP modulo RAS_DEPTH, load RAS_TOP with entry[WP-1], and decrement CNT.
REQ-034 RET/RETID/RETIE with CNT=0 SHALL leave WP, CNT and RAS_TOP unchanged and pulse RAS_UNDERFLOW.
REQ-035 RAS_EMPTY SHALL be high exactly when CNT=0.
REQ-036 Stack operations SHALL occur only when RES_VALID is high; at most one push or pop per cycle.

Reset
REQ-037 On RST_N low, asynchronously: all counters SHALL be 2'b01 (weakly not-taken).
REQ-038 On RST_N low: WP=0, CNT=0, and all outputs 0 except RAS_EMPTY=1.
REQ-039 Reset asserted mid-operation SHALL discard any in-flight resolve; no RES_DONE pulse follows release.
REQ-040 The first edge after RST_N rises SHALL operate normally.

Verification
REQ-041 After reset, PRED_VALID with IDX 3 -> PRED_TAKEN=0 next cycle.
REQ-042 Two BREQ resolves with Z=1 at IDX 3 -> counter 3; a following predict of IDX 3 -> PRED_TAKEN=1.
REQ-043 Saturation: a third taken BREQ at IDX 3 -> counter stays 3; four BRNE with Z=1 (not taken) -> counter 0, then stays 0.
REQ-044 BRCS with C=0 and RES_PREDICTED=1 -> BRANCH_TAKEN=0, BRANCH_MISS=1, RES_DONE pulses for 1 cycle.
REQ-045 RAS_DEPTH+1 CALLs with addresses 1..9, then 9 RETs -> RAS_TOP sequence 9,8,...,2; ninth RET pulses RAS_UNDERFLOW with RAS_TOP still 2; RAS_EMPTY=1.
REQ-046 RST_N pulled low during a RES_VALID cycle -> outputs 0 immediately, RAS_EMPTY=1, no RES_DONE after release.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: 2-bit bimodal counter table, flag-based taken resolution
// and a circular return-address stack that overwrites its oldest entry when full.
module branch_resolve_unit #(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pred_valid,
    input  logic [IDX_W-1:0]  i_pred_idx,
    output logic              o_pred_taken,
    input  logic              i_res_valid,
    input  logic [3:0]        i_res_type,
    input  logic              i_c,
    input  logic              i_z,
    input  logic [IDX_W-1:0]  i_res_idx,
    input  logic              i_res_predicted,
    input  logic [ADDR_W-1:0] i_res_ret_addr,
    output logic              o_branch_taken,
    output logic              o_branch_miss,
    output logic              o_res_done,
    output logic [ADDR_W-1:0] o_ras_top,
    output logic              o_ras_empty,
    output logic              o_ras_underflow
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    localparam logic [3:0] T_BRCC  = 4'h1;
    localparam logic [3:0] T_BRCS  = 4'h2;
    localparam logic [3:0] T_BREQ  = 4'h3;
    localparam logic [3:0] T_BRN   = 4'h4;
    localparam logic [3:0] T_BRNE  = 4'h5;
    localparam logic [3:0] T_CALL  = 4'h6;
    localparam logic [3:0] T_RET   = 4'h7;
    localparam logic [3:0] T_RETID = 4'h8;
    localparam logic [3:0] T_RETIE = 4'h9;

    logic [1:0]        r_bht [BHT_ENTRIES];
    logic [ADDR_W-1:0] r_ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pred_taken;
    logic              r_branch_taken;
    logic              r_branch_miss;
    logic              r_res_done;
    logic [ADDR_W-1:0] r_ras_top;
    logic              r_ras_underflow;

    logic              w_taken;
    logic              w_is_cond;
    logic              w_is_call;
    logic              w_is_ret;
    logic [1:0]        w_ctr_cur;
    logic [1:0]        w_ctr_nxt;
    logic [PTR_W-1:0]  w_wp_inc;
    logic [PTR_W-1:0]  w_wp_dec;
    logic              w_push;
    logic              w_pop;
    logic              w_underflow;

    always_comb begin
        w_taken   = 1'b0;
        w_is_cond = 1'b0;
        w_is_call = 1'b0;
        w_is_ret  = 1'b0;
        case (i_res_type)
            T_BRCC: begin w_taken = ~i_c; w_is_cond = 1'b1; end
            T_BRCS: begin w_taken = i_c;  w_is_cond = 1'b1; end
            T_BREQ: begin w_taken = i_z;  w_is_cond = 1'b1; end
            T_BRNE: begin w_taken = ~i_z; w_is_cond = 1'b1; end
            T_BRN:  w_taken = 1'b1;
            T_CALL: begin w_taken = 1'b1; w_is_call = 1'b1; end
            T_RET, T_RETID, T_RETIE: begin w_taken = 1'b1; w_is_ret = 1'b1; end
            default: w_taken = 1'b0;
        endcase
    end

    // Saturating 2-bit counter step
    always_comb begin
        w_ctr_cur = r_bht[i_res_idx];
        w_ctr_nxt = w_ctr_cur;
        if (w_taken) begin
            if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'b01;
        end
    end

    always_comb begin
        w_wp_inc    = (r_wp == PTR_MAX) ? '0 : r_wp + 1'b1;
        w_wp_dec    = (r_wp == '0) ? PTR_MAX : r_wp - 1'b1;
        w_push      = i_res_valid & w_is_call;
        w_pop       = i_res_valid & w_is_ret & (r_cnt != '0);
        w_underflow = i_res_valid & w_is_ret & (r_cnt == '0);
    end

    // Prediction reads the pre-update counter value; no bypass from the resolve port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) r_bht[i] <= 2'b01;
            r_pred_taken <= 1'b0;
        end else begin
            if (i_pred_valid) r_pred_taken <= r_bht[i_pred_idx][1];
            if (i_res_valid && w_is_cond) r_bht[i_res_idx] <= w_ctr_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_branch_taken  <= 1'b0;
            r_branch_miss   <= 1'b0;
            r_res_done      <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else begin
            r_res_done      <= i_res_valid;
            r_ras_underflow <= w_underflow;
            if (i_res_valid) begin
                r_branch_taken <= w_taken;
                r_branch_miss  <= w_taken ^ i_res_predicted;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp      <= '0;
            r_cnt     <= '0;
            r_ras_top <= '0;
        end else if (w_push) begin
            r_wp <= w_wp_inc;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end else if (w_pop) begin
            r_wp      <= w_wp_dec;
            r_cnt     <= r_cnt - 1'b1;
            r_ras_top <= r_ras_mem[w_wp_dec];
        end
    end

    // Stack storage needs no reset: entries are only read when CNT says they are live
    always_ff @(posedge i_clk) begin
        if (w_push) r_ras_mem[r_wp] <= i_res_ret_addr;
    end

    assign o_pred_taken    = r_pred_taken;
    assign o_branch_taken  = r_branch_taken;
    assign o_branch_miss   = r_branch_miss;
    assign o_res_done      = r_res_done;
    assign o_ras_top       = r_ras_top;
    assign o_ras_empty     = (r_cnt == '0);
    assign o_ras_underflow = r_ras_underflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue/array reference model produces
// expectations at issue time; a negedge monitor pops and compares as outputs appear.
module tb_branch_resolve_unit;

    localparam int BHT_ENTRIES = 16;
    localparam int IDX_W       = 4;
    localparam int ADDR_W      = 10;
    localparam int RAS_DEPTH   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pred_valid = 1'b0;
    logic [IDX_W-1:0]  pred_idx = '0;
    logic              pred_taken;
    logic              res_valid = 1'b0;
    logic [3:0]        res_type = '0;
    logic              c = 1'b0;
    logic              z = 1'b0;
    logic [IDX_W-1:0]  res_idx = '0;
    logic              res_predicted = 1'b0;
    logic [ADDR_W-1:0] ret_addr = '0;
    logic              branch_taken, branch_miss, res_done, ras_empty, ras_underflow;
    logic [ADDR_W-1:0] ras_top;

    branch_resolve_unit #(
        .BHT_ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pred_valid(pred_valid), .i_pred_idx(pred_idx), .o_pred_taken(pred_taken),
        .i_res_valid(res_valid), .i_res_type(res_type), .i_c(c), .i_z(z),
        .i_res_idx(res_idx), .i_res_predicted(res_predicted), .i_res_ret_addr(ret_addr),
        .o_branch_taken(branch_taken), .o_branch_miss(branch_miss), .o_res_done(res_done),
        .o_ras_top(ras_top), .o_ras_empty(ras_empty), .o_ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int taken;
        int miss;
        int underflow;
        int top;
        int empty;
    } res_exp_t;

    res_exp_t res_q[$];
    int       pred_q[$];
    int       ctr[BHT_ENTRIES];
    int       ras_q[$];
    int       model_top;
    int       last_pred;
    int       n_checks = 0;
    int       n_pass = 0;
    logic     pred_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] = 1;
        ras_q.delete();
        model_top = 0;
        last_pred = 0;
    endtask

    // Drive one cycle of stimulus just after the rising edge and record expectations
    task automatic issue(input bit pv, input int pidx, input bit rv, input int typ,
                         input bit fc, input bit fz, input int ridx, input bit rp,
                         input int addr);
        res_exp_t e;
        int       tk;
        @(posedge clk);
        #1;
        pred_valid = pv; pred_idx = IDX_W'(pidx);
        res_valid = rv; res_type = 4'(typ); c = fc; z = fz;
        res_idx = IDX_W'(ridx); res_predicted = rp; ret_addr = ADDR_W'(addr);
        if (pv) pred_q.push_back(ctr[pidx] >= 2 ? 1 : 0);
        if (rv) begin
            case (typ)
                1: tk = fc ? 0 : 1;
                2: tk = fc ? 1 : 0;
                3: tk = fz ? 1 : 0;
                5: tk = fz ? 0 : 1;
                4, 6, 7, 8, 9: tk = 1;
                default: tk = 0;
            endcase
            if (typ == 1 || typ == 2 || typ == 3 || typ == 5) begin
                if (tk == 1) ctr[ridx] = (ctr[ridx] == 3) ? 3 : ctr[ridx] + 1;
                else         ctr[ridx] = (ctr[ridx] == 0) ? 0 : ctr[ridx] - 1;
            end
            e.underflow = 0;
            if (typ == 6) begin
                ras_q.push_back(addr);
                if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
            end else if (typ >= 7 && typ <= 9) begin
                if (ras_q.size() == 0) e.underflow = 1;
                else model_top = ras_q.pop_back();
            end
            e.taken = tk;
            e.miss  = (tk != int'(rp)) ? 1 : 0;
            e.top   = model_top;
            e.empty = (ras_q.size() == 0) ? 1 : 0;
            res_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pred_seen <= 1'b0;
        else        pred_seen <= pred_valid;
    end

    always @(negedge clk) begin
        res_exp_t e;
        if (rst_n) begin
            if (pred_seen) begin
                if (pred_q.size() == 0) chk("pred_q underrun", 1, 0);
                else begin
                    last_pred = pred_q.pop_front();
                    chk("pred_taken", int'(pred_taken), last_pred);
                end
            end
            if (res_done) begin
                if (res_q.size() == 0) chk("unexpected res_done", 1, 0);
                else begin
                    e = res_q.pop_front();
                    chk("branch_taken", int'(branch_taken), e.taken);
                    chk("branch_miss", int'(branch_miss), e.miss);
                    chk("ras_underflow", int'(ras_underflow), e.underflow);
                    chk("ras_top", int'(ras_top), e.top);
                    chk("ras_empty", int'(ras_empty), e.empty);
                    chk("pred_taken hold", int'(pred_taken), last_pred);
                end
            end else if (ras_underflow) begin
                chk("underflow without res_done", 1, 0);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pred_taken"}, int'(pred_taken), 0);
        chk({tag, " branch_taken"}, int'(branch_taken), 0);
        chk({tag, " branch_miss"}, int'(branch_miss), 0);
        chk({tag, " res_done"}, int'(res_done), 0);
        chk({tag, " ras_top"}, int'(ras_top), 0);
        chk({tag, " ras_empty"}, int'(ras_empty), 1);
        chk({tag, " ras_underflow"}, int'(ras_underflow), 0);
    endtask

    initial begin
        int r, typ;
        model_reset();
        #2;
        chk_reset_outputs("reset");
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fresh counters predict not-taken
        issue(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // Two taken BREQs at idx 3 then predict
        issue(0, 0, 1, 3, 0, 1, 3, 0, 0);
        issue(0, 0, 1, 3, 0, 1, 3, 0, 0);
        issue(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // Saturate high, then drive down with not-taken BRNE
        issue(0, 0, 1, 3, 0, 1, 3, 1, 0);
        issue(1, 3, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) issue(0, 0, 1, 5, 0, 1, 3, 1, 0);
        issue(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // Same-cycle predict and update at one index uses the old value
        issue(1, 3, 1, 3, 0, 1, 3, 0, 0);
        issue(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // BRCS not taken while predicted taken
        issue(0, 0, 1, 2, 0, 0, 5, 1, 0);
        idle(1);
        // Overfill the stack, then drain it past empty
        for (int a = 1; a <= RAS_DEPTH + 1; a++) issue(0, 0, 1, 6, 0, 0, 0, 1, a);
        for (int i = 0; i < RAS_DEPTH + 1; i++) issue(0, 0, 1, 7 + (i % 3), 0, 0, 0, 1, 0);
        idle(2);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      typ = 6;
            else if (r < 45) typ = 7 + $urandom_range(0, 2);
            else             typ = $urandom_range(0, 15);
            issue($urandom_range(0, 1), $urandom_range(0, BHT_ENTRIES - 1),
                  ($urandom_range(0, 3) != 0), typ, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, BHT_ENTRIES - 1),
                  $urandom_range(0, 1), $urandom_range(0, (1 << ADDR_W) - 1));
        end

        // Mid-operation reset: make outputs non-zero, then reset during a resolve cycle
        issue(0, 0, 1, 6, 0, 0, 0, 0, 77);
        issue(1, 3, 1, 3, 0, 1, 3, 0, 0);
        issue(0, 0, 1, 3, 0, 1, 3, 0, 0);
        idle(2);
        chk("queues drained before reset", res_q.size() + pred_q.size(), 0);
        @(posedge clk);
        #1;
        res_valid = 1'b1; res_type = 4'h6; ret_addr = 10'd55; res_predicted = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid-reset");
        res_valid = 1'b0; res_type = 4'h0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no res_done after reset", int'(res_done), 0);
        end
        issue(1, 3, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 1, 7, 0, 0, 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            typ = ($urandom_range(0, 1) == 1) ? 6 : $urandom_range(0, 15);
            issue($urandom_range(0, 1), $urandom_range(0, BHT_ENTRIES - 1), 1'b1, typ,
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, BHT_ENTRIES - 1), $urandom_range(0, 1),
                  $urandom_range(0, (1 << ADDR_W) - 1));
        end
        idle(3);
        chk("res_q drained", res_q.size(), 0);
        chk("pred_q drained", pred_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
